// File: rtl/l2_ddr_scheduler_pkg.sv
// Shared definitions for the L2-to-DDR burst scheduler.
package l2_ddr_scheduler_pkg;

  localparam int unsigned BURST_BEATS_DFLT = 8;
  localparam int unsigned ADDR_W_DFLT      = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/l2_ddr_base_reg.sv
// Single-port DDR base address register: load, inc/dec nudges, burst advance, wrap.
module l2_ddr_base_reg
  import l2_ddr_scheduler_pkg::*;
#(
  parameter int unsigned BURST_BEATS = BURST_BEATS_DFLT,
  parameter int unsigned ADDR_W      = ADDR_W_DFLT
) (
  input  logic              clk_166M66,
  input  logic              mcu_sys_rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  input  logic              dec,
  input  logic              burst_add,
  output logic [ADDR_W-1:0] base
);

  // Load wins outright; otherwise sum burst advance and nudges, wrapping naturally.
  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      base <= '0;
    end else if (load) begin
      base <= load_value;
    end else begin
      base <= base
            + (burst_add ? ADDR_W'(BURST_BEATS) : ADDR_W'(0))
            + ADDR_W'(inc)
            - ADDR_W'(dec);
    end
  end

endmodule

// File: rtl/l2_ddr_scheduler.sv
// Round-robin arbiter and burst sequencer sharing one DDR channel between two L2s.
module l2_ddr_scheduler
  import l2_ddr_scheduler_pkg::*;
#(
  parameter int unsigned BURST_BEATS = BURST_BEATS_DFLT,
  parameter int unsigned ADDR_W      = ADDR_W_DFLT
) (
  input  logic              clk_166M66,
  input  logic              mcu_sys_rst_n,
  input  logic [1:0]        i_req_operate_enable,
  input  logic [1:0]        i_req_rw,
  input  logic [1:0]        i_req_base_addr_inc,
  input  logic [1:0]        i_req_base_addr_dec,
  input  logic              i_base_load,
  input  logic              i_base_load_port,
  input  logic [ADDR_W-1:0] i_base_load_value,
  output logic [1:0]        o_req_bus_enable,
  output logic [1:0]        o_req_operate_lock,
  output logic              o_ddr_cmd_valid,
  input  logic              i_ddr_cmd_ready,
  output logic              o_ddr_cmd_rw,
  output logic [ADDR_W-1:0] o_ddr_cmd_addr,
  input  logic              i_ddr_beat_valid,
  output logic              o_grant_port,
  output logic              o_protocol_err
);

  localparam int unsigned      CNT_W     = $clog2(BURST_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  sched_state_e      state;
  logic              rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pick;
  logic [ADDR_W-1:0] base [2];

  // Per-port base registers; the burst advance lands on the owner during RELEASE.
  for (genvar p = 0; p < 2; p++) begin : g_base
    l2_ddr_base_reg #(
      .BURST_BEATS (BURST_BEATS),
      .ADDR_W      (ADDR_W)
    ) u_base_reg (
      .clk_166M66    (clk_166M66),
      .mcu_sys_rst_n (mcu_sys_rst_n),
      .load          (i_base_load && (i_base_load_port == 1'(p))),
      .load_value    (i_base_load_value),
      .inc           (i_req_base_addr_inc[p]),
      .dec           (i_req_base_addr_dec[p]),
      .burst_add     ((state == ST_RELEASE) && (o_grant_port == 1'(p))),
      .base          (base[p])
    );
  end

  // Lone requester wins; on contention the round-robin pointer decides.
  always_comb begin
    pick = rr_ptr;
    if (i_req_operate_enable == 2'b01) pick = 1'b0;
    else if (i_req_operate_enable == 2'b10) pick = 1'b1;
  end

  // Beat strobes pass straight through to the owning port while in DATA.
  assign o_req_bus_enable = (state == ST_DATA && i_ddr_beat_valid)
                          ? (o_grant_port ? 2'b10 : 2'b01) : 2'b00;

  // Burst sequencer, round-robin pointer, beat counter and sticky error flag.
  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state              <= ST_IDLE;
      rr_ptr             <= 1'b0;
      beat_cnt           <= '0;
      o_grant_port       <= 1'b0;
      o_ddr_cmd_valid    <= 1'b0;
      o_ddr_cmd_rw       <= 1'b0;
      o_ddr_cmd_addr     <= '0;
      o_req_operate_lock <= 2'b00;
      o_protocol_err     <= 1'b0;
    end else begin
      if ((i_ddr_beat_valid && state != ST_DATA) ||
          (i_ddr_cmd_ready && state != ST_CMD)) begin
        o_protocol_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (|i_req_operate_enable) begin
            o_grant_port       <= pick;
            o_ddr_cmd_rw       <= i_req_rw[pick];
            o_ddr_cmd_addr     <= base[pick];
            o_ddr_cmd_valid    <= 1'b1;
            o_req_operate_lock <= pick ? 2'b01 : 2'b10;
            state              <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_ddr_cmd_ready) begin
            o_ddr_cmd_valid <= 1'b0;
            beat_cnt        <= '0;
            state           <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_ddr_beat_valid) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rr_ptr             <= ~o_grant_port;
          o_req_operate_lock <= 2'b00;
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
